// File: rtl/rbcp_to_bus_ack_pkg.sv
// Shared types for the RBCP to basil bus bridge.
// FSM encoding, timer width and counter helper.
package rbcp_to_bus_ack_pkg;

  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_LAT    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rbcp_to_bus_ack_if.sv
// RBCP request/response and basil bus control bundle.
// The bridge takes the master side; SiTCP and slaves the other.
interface rbcp_to_bus_ack_if #(
  parameter int unsigned ABUSWIDTH = 32
);
  logic                 rbcp_act;
  logic [31:0]          rbcp_addr;
  logic [7:0]           rbcp_wd;
  logic                 rbcp_we;
  logic                 rbcp_re;
  logic                 rbcp_ack;
  logic [7:0]           rbcp_rd;
  logic                 bus_wr;
  logic                 bus_rd;
  logic [ABUSWIDTH-1:0] bus_add;
  logic                 bus_ack_req;
  logic                 bus_ack;

  modport master (
    input  rbcp_act, rbcp_addr, rbcp_wd,
    input  rbcp_we, rbcp_re,
    input  bus_ack_req, bus_ack,
    output rbcp_ack, rbcp_rd,
    output bus_wr, bus_rd, bus_add
  );

  modport slave (
    output rbcp_act, rbcp_addr, rbcp_wd,
    output rbcp_we, rbcp_re,
    output bus_ack_req, bus_ack,
    input  rbcp_ack, rbcp_rd,
    input  bus_wr, bus_rd, bus_add
  );
endinterface

// File: rtl/rbcp_to_bus_ack_timer.sv
// Loadable 16-bit down-counter shared by the
// read-latency and slave wait-state phases.
module rbcp_to_bus_ack_timer
  import rbcp_to_bus_ack_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [TMR_W-1:0] i_load,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/rbcp_to_bus_ack.sv
// Registered RBCP to basil 8-bit bus bridge with
// read latency, slave wait states, timeout and abort.
module rbcp_to_bus_ack
  import rbcp_to_bus_ack_pkg::*;
#(
  parameter int unsigned ABUSWIDTH    = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  rbcp_to_bus_ack_if.master bus,
  inout  wire  [7:0]        io_bus_data,
  output logic [7:0]        o_timeout_cnt
);

  localparam logic [TMR_W-1:0] LAT_LOAD =
    TMR_W'(READ_LATENCY - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD =
    TMR_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_we;
  logic [7:0]       r_wd;
  logic             w_start;
  logic             w_clear;
  logic             w_expired;
  logic             w_drv;
  logic [TMR_W-1:0] w_load;

  // Timer is armed in the strobe cycle for whichever phase follows.
  assign w_start = (r_state == S_ACCESS);
  assign w_clear = (r_state == S_IDLE);
  assign w_load  = bus.bus_ack_req ? TMO_LOAD : LAT_LOAD;

  assign w_drv       = (r_state == S_ACCESS) && r_we;
  assign io_bus_data = w_drv ? r_wd : 8'bz;

  rbcp_to_bus_ack_timer u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_start),
    .i_clear   (w_clear),
    .i_load    (w_load),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_wd          <= '0;
      bus.bus_wr    <= 1'b0;
      bus.bus_rd    <= 1'b0;
      bus.bus_add   <= '0;
      bus.rbcp_ack  <= 1'b0;
      bus.rbcp_rd   <= '0;
      o_timeout_cnt <= '0;
    end else begin
      bus.bus_wr   <= 1'b0;
      bus.bus_rd   <= 1'b0;
      bus.rbcp_ack <= 1'b0;
      bus.rbcp_rd  <= '0;
      if (r_state != S_IDLE && !bus.rbcp_act) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.rbcp_we || bus.rbcp_re) begin
              bus.bus_add <= bus.rbcp_addr[ABUSWIDTH-1:0];
              r_wd        <= bus.rbcp_wd;
              r_we        <= bus.rbcp_we;
              bus.bus_wr  <= bus.rbcp_we;
              bus.bus_rd  <= !bus.rbcp_we;
              r_state     <= S_ACCESS;
            end
          end
          S_ACCESS: begin
            if (bus.bus_ack_req) begin
              r_state <= S_WAIT;
            end else if (r_we) begin
              bus.rbcp_ack <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_LAT;
            end
          end
          S_LAT: begin
            if (w_expired) begin
              bus.rbcp_ack <= 1'b1;
              bus.rbcp_rd  <= io_bus_data;
              r_state      <= S_DONE;
            end
          end
          S_WAIT: begin
            if (bus.bus_ack) begin
              bus.rbcp_ack <= 1'b1;
              bus.rbcp_rd  <= r_we ? 8'h00 : io_bus_data;
              r_state      <= S_DONE;
            end else if (w_expired) begin
              bus.rbcp_ack  <= 1'b1;
              bus.rbcp_rd   <= r_we ? 8'h00 : TIMEOUT_DATA;
              o_timeout_cnt <= sat_inc(o_timeout_cnt);
              r_state       <= S_DONE;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rbcp_to_bus_ack.sv
// Scoreboard bench for rbcp_to_bus_ack: expected ACK cycle
// and RBCP_RD queued per request, popped on RBCP_ACK.
module tb_rbcp_to_bus_ack;
  import rbcp_to_bus_ack_pkg::*;

  typedef struct {
    logic [7:0] rd;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_oe = 1'b0;
  logic [7:0] s_data = '0;
  wire  [7:0] bus_data;
  logic [7:0] tmo_cnt;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_wr = 0;
  int   n_rd = 0;
  int   m_tmo = 0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  exp_t sb[$];

  rbcp_to_bus_ack_if #(.ABUSWIDTH(32)) bus_if ();

  assign bus_data = s_oe ? s_data : 8'bz;

  rbcp_to_bus_ack #(
    .ABUSWIDTH    (32),
    .READ_LATENCY (2),
    .TIMEOUT      (8),
    .TIMEOUT_DATA (8'hFF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus_if.master),
    .io_bus_data   (bus_data),
    .o_timeout_cnt (tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle request; lat==0 means no ACK is due.
  task automatic req(
    input logic        we,
    input logic        re,
    input logic [31:0] a,
    input logic [7:0]  d,
    input logic [7:0]  exp_rd,
    input int          lat
  );
    exp_t e;
    bus_if.rbcp_we   = we;
    bus_if.rbcp_re   = re;
    bus_if.rbcp_addr = a;
    bus_if.rbcp_wd   = d;
    if (lat > 0) begin
      e.rd = exp_rd;
      e.at = cyc + lat;
      sb.push_back(e);
    end
    tick();
    bus_if.rbcp_we = 1'b0;
    bus_if.rbcp_re = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_if.rbcp_ack) begin
      chk("ack_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.at);
        chk("rbcp_rd", bus_if.rbcp_rd, e.rd);
      end
    end
    if (bus_if.bus_wr) begin
      n_wr++;
      chk("wr_one_cycle", prev_wr, 0);
    end
    if (bus_if.bus_rd) begin
      n_rd++;
      chk("rd_one_cycle", prev_rd, 0);
    end
    prev_wr = bus_if.bus_wr;
    prev_rd = bus_if.bus_rd;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    bus_if.rbcp_act    = 1'b1;
    bus_if.rbcp_addr   = '0;
    bus_if.rbcp_wd     = '0;
    bus_if.rbcp_we     = 1'b0;
    bus_if.rbcp_re     = 1'b0;
    bus_if.bus_ack_req = 1'b0;
    bus_if.bus_ack     = 1'b0;
    tick(3);
    chk("rst_ack", bus_if.rbcp_ack, 0);
    chk("rst_rd", bus_if.rbcp_rd, 0);
    chk("rst_wr", bus_if.bus_wr, 0);
    chk("rst_rdstb", bus_if.bus_rd, 0);
    chk("rst_add", bus_if.bus_add, 0);
    chk("rst_tmo", tmo_cnt, 0);
    chk("rst_z", 32'(bus_data === 8'hzz), 1);
    rst = 1'b0;
    tick(2);

    // Plain write, then a back-to-back read
    req(1, 0, 32'h10, 8'hA5, 8'h00, 2);
    chk("w_wr_c1", bus_if.bus_wr, 1);
    chk("w_data_c1", bus_data, 8'hA5);
    chk("w_add_c1", bus_if.bus_add, 32'h10);
    chk("w_rd_c1", bus_if.bus_rd, 0);
    tick();
    chk("w_wr_c2", bus_if.bus_wr, 0);
    chk("w_add_c2", bus_if.bus_add, 32'h10);
    tick();
    s_oe = 1'b1;
    s_data = 8'h3C;
    req(0, 1, 32'h20, 8'h00, 8'h3C, 4);
    chk("r_rd_c1", bus_if.bus_rd, 1);
    chk("r_add_c1", bus_if.bus_add, 32'h20);
    tick();
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    tick(2);
    s_oe = 1'b0;

    // Wait-state read acknowledged after five cycles
    req(0, 1, 32'h30, 8'h00, 8'h77, 7);
    bus_if.bus_ack_req = 1'b1;
    tick();
    bus_if.bus_ack_req = 1'b0;
    chk("wt_rd_c2", bus_if.bus_rd, 0);
    tick(4);
    bus_if.bus_ack = 1'b1;
    s_oe = 1'b1;
    s_data = 8'h77;
    tick();
    bus_if.bus_ack = 1'b0;
    s_oe = 1'b0;
    tick();

    // Timed-out read
    req(0, 1, 32'h40, 8'h00, 8'hFF, 10);
    bus_if.bus_ack_req = 1'b1;
    tick();
    bus_if.bus_ack_req = 1'b0;
    tick(9);
    m_tmo = 1;
    chk("tmo_first", tmo_cnt, 32'(m_tmo));

    // Abort in WAIT, then a write straight after
    req(1, 0, 32'h50, 8'h11, 8'h00, 0);
    chk("ab_data_c1", bus_data, 8'h11);
    bus_if.bus_ack_req = 1'b1;
    tick();
    bus_if.bus_ack_req = 1'b0;
    chk("ab_z_wait", 32'(bus_data === 8'hzz), 1);
    tick();
    bus_if.rbcp_act = 1'b0;
    tick();
    chk("ab_wr", bus_if.bus_wr, 0);
    chk("ab_z", 32'(bus_data === 8'hzz), 1);
    bus_if.rbcp_act = 1'b1;
    req(1, 0, 32'h44, 8'h5A, 8'h00, 2);
    chk("ab_next_data", bus_data, 8'h5A);
    tick(12);
    chk("ab_tmo", tmo_cnt, 32'(m_tmo));

    // WE+RE together, stray ACK_REQ while IDLE
    w0 = n_wr;
    r0 = n_rd;
    bus_if.bus_ack_req = 1'b1;
    req(1, 1, 32'h60, 8'h99, 8'h00, 2);
    bus_if.bus_ack_req = 1'b0;
    tick(2);
    chk("both_wr", n_wr, w0 + 1);
    chk("both_rd", n_rd, r0);

    // Extra WE while the read is in LAT
    w0 = n_wr;
    r0 = n_rd;
    s_oe = 1'b1;
    s_data = 8'hC3;
    req(0, 1, 32'h70, 8'h00, 8'hC3, 4);
    tick();
    bus_if.rbcp_we = 1'b1;
    bus_if.rbcp_wd = 8'hEE;
    tick();
    bus_if.rbcp_we = 1'b0;
    tick(2);
    s_oe = 1'b0;
    chk("lat_we_wr", n_wr, w0);
    chk("lat_we_rd", n_rd, r0 + 1);

    // Saturating timeout counter, 300 timeouts total
    for (int i = 0; i < 299; i++) begin
      logic we;
      we = (i % 2) == 1;
      req(we, !we, 32'(i), 8'(i),
          we ? 8'h00 : 8'hFF, 10);
      bus_if.bus_ack_req = 1'b1;
      tick();
      bus_if.bus_ack_req = 1'b0;
      tick(9);
      if (m_tmo < 255) m_tmo++;
      chk("tmo_sat", tmo_cnt, 32'(m_tmo));
    end
    chk("tmo_255", tmo_cnt, 255);

    // Reset in the middle of a WAIT
    req(0, 1, 32'h80, 8'h00, 8'h00, 0);
    bus_if.bus_ack_req = 1'b1;
    tick();
    bus_if.bus_ack_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    m_tmo = 0;
    chk("mr_ack", bus_if.rbcp_ack, 0);
    chk("mr_rdstb", bus_if.bus_rd, 0);
    chk("mr_add", bus_if.bus_add, 0);
    chk("mr_tmo", tmo_cnt, 32'(m_tmo));
    chk("mr_z", 32'(bus_data === 8'hzz), 1);
    tick(2);
    rst = 1'b0;
    tick();
    req(1, 0, 32'h90, 8'h3E, 8'h00, 2);
    chk("mr_next_add", bus_if.bus_add, 32'h90);
    tick(12);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
